line_window_3x3_p: RTL and testbench

- Parametrised 3x3 sliding-window generator for the SIFT front end (Gaussian/DoG filters).
- Successor to the fixed 8-bit, free-running window block. Adds the following:
  - configurable pixel width and frame size;
  - input valid qualification (stalls);
  - frame-start resynchronisation;
  - per-frame first/last window markers.
- Accepts one raster-order pixel per valid beat and emits a registered 3x3 neighbourhood for every interior pixel.

---
 rtl/sift_win_pkg.sv | 23 ++
 rtl/line_buffer_ram.sv | 27 ++
 rtl/line_window_3x3_p.sv | 114 +++++++++++
 tb/tb_line_window_3x3_p.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sift_win_pkg.sv
// Shared constants for the SIFT 3x3 window front end.
// Window slot indices and a counter-width helper.
package sift_win_pkg;

    localparam int WIN_TL = 0;
    localparam int WIN_TC = 1;
    localparam int WIN_TR = 2;
    localparam int WIN_ML = 3;
    localparam int WIN_C  = 4;
    localparam int WIN_MR = 5;
    localparam int WIN_BL = 6;
    localparam int WIN_BC = 7;
    localparam int WIN_BR = 8;

    // Bits needed to hold 0..n-1; never less than one bit.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/line_buffer_ram.sv
// Single-port line buffer: asynchronous read, synchronous write.
// A read and a write to the same address in one cycle return the old word.
module line_buffer_ram
    import sift_win_pkg::*;
#(
    parameter int DW    = 8,
    parameter int DEPTH = 640,
    parameter int AW    = clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    assign rdata = mem[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/line_window_3x3_p.sv
// Raster-order 3x3 sliding-window generator with stall and frame-start resync.
// Define WIN_COORD_EN to add the window-centre coordinate outputs win_cx/win_cy.
module line_window_3x3_p
    import sift_win_pkg::*;
#(
    parameter int DW    = 8,
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      din_valid,
    input  logic                      sof,
    input  logic [DW-1:0]             din,
    output logic                      win_valid,
    output logic [9*DW-1:0]           win,
    output logic                      start_flag,
    output logic                      eof_flag
`ifdef WIN_COORD_EN
    ,
    output logic [clog2(IMG_W)-1:0]   win_cx,
    output logic [clog2(IMG_H)-1:0]   win_cy
`endif
);

    localparam int CW = clog2(IMG_W);
    localparam int RW = clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    // There is no ready: every cycle with din_valid=1 (out of reset) consumes
    // din/sof; win_valid is a one-cycle qualifier with no back-pressure.
    logic          accept;
    logic [CW-1:0] col, pcol;
    logic [RW-1:0] row, prow;
    logic [DW-1:0] lb0_rd, lb1_rd;
    logic [DW-1:0] sr [9];
    logic          win_hit;

    assign accept  = din_valid & rst;
    assign pcol    = sof ? '0 : col;
    assign prow    = sof ? '0 : row;
    assign win_hit = accept && (prow >= ROW_TWO) && (pcol >= COL_TWO);

    line_buffer_ram #(.DW(DW), .DEPTH(IMG_W), .AW(CW)) u_lb0 (
        .clk   (clk),
        .we    (accept),
        .addr  (pcol),
        .wdata (din),
        .rdata (lb0_rd)
    );

    line_buffer_ram #(.DW(DW), .DEPTH(IMG_W), .AW(CW)) u_lb1 (
        .clk   (clk),
        .we    (accept),
        .addr  (pcol),
        .wdata (lb0_rd),
        .rdata (lb1_rd)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            col        <= '0;
            row        <= '0;
            win_valid  <= 1'b0;
            start_flag <= 1'b0;
            eof_flag   <= 1'b0;
            for (int k = 0; k < 9; k++) begin
                sr[k] <= '0;
            end
`ifdef WIN_COORD_EN
            win_cx     <= '0;
            win_cy     <= '0;
`endif
        end else begin
            win_valid  <= win_hit;
            start_flag <= win_hit && (prow == ROW_TWO) && (pcol == COL_TWO);
            eof_flag   <= win_hit && (prow == ROW_LAST) && (pcol == COL_LAST);
            if (accept) begin
                sr[WIN_TL] <= sr[WIN_TC];
                sr[WIN_TC] <= sr[WIN_TR];
                sr[WIN_TR] <= lb1_rd;
                sr[WIN_ML] <= sr[WIN_C];
                sr[WIN_C]  <= sr[WIN_MR];
                sr[WIN_MR] <= lb0_rd;
                sr[WIN_BL] <= sr[WIN_BC];
                sr[WIN_BC] <= sr[WIN_BR];
                sr[WIN_BR] <= din;
                if (pcol == COL_LAST) begin
                    col <= '0;
                    row <= (prow == ROW_LAST) ? '0 : prow + RW'(1);
                end else begin
                    col <= pcol + CW'(1);
                    row <= prow;
                end
`ifdef WIN_COORD_EN
                // Coordinates follow valid windows only, so they always name the
                // centre of the window last flagged by win_valid.
                if (win_hit) begin
                    win_cx <= pcol - CW'(1);
                    win_cy <= prow - RW'(1);
                end
`endif
            end
        end
    end

    for (genvar k = 0; k < 9; k++) begin : g_win
        assign win[k*DW +: DW] = sr[k];
    end

endmodule

// File: tb/tb_line_window_3x3_p.sv
// Directed and randomized bench for line_window_3x3_p against a frame-image model.
// The model stores every accepted pixel at its raster position and cuts windows from it.
module tb_line_window_3x3_p;

    localparam int DW = 8;
    localparam int W  = 8;
    localparam int H  = 6;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            din_valid = 1'b0;
    logic            sof = 1'b0;
    logic [DW-1:0]   din = '0;
    logic            win_valid;
    logic [9*DW-1:0] win;
    logic            start_flag;
    logic            eof_flag;
`ifdef WIN_COORD_EN
    logic [2:0]      win_cx;
    logic [2:0]      win_cy;
`endif

    always #5 clk = ~clk;

    line_window_3x3_p #(.DW(DW), .IMG_W(W), .IMG_H(H)) dut (
        .clk        (clk),
        .rst        (rst),
        .din_valid  (din_valid),
        .sof        (sof),
        .din        (din),
        .win_valid  (win_valid),
        .win        (win),
        .start_flag (start_flag),
        .eof_flag   (eof_flag)
`ifdef WIN_COORD_EN
        ,
        .win_cx     (win_cx),
        .win_cy     (win_cy)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [DW-1:0] img [H][W];
    int            mr = 0;
    int            mc = 0;
    logic          exp_valid = 1'b0;
    logic          exp_start = 1'b0;
    logic          exp_eof   = 1'b0;
    logic          win_known = 1'b1;
    logic [71:0]   exp_win   = '0;
    logic [2:0]    exp_cx    = '0;
    logic [2:0]    exp_cy    = '0;

    int            obs_win   = 0;
    int            obs_start = 0;
    int            obs_eof   = 0;
    logic [71:0]   first_win = '0;
    logic [7:0]    last_br   = '0;

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    task automatic check_outputs();
        chk("win_valid", 72'(win_valid), 72'(exp_valid));
        chk("start_flag", 72'(start_flag), 72'(exp_start));
        chk("eof_flag", 72'(eof_flag), 72'(exp_eof));
        if (win_known) chk("win", win, exp_win);
`ifdef WIN_COORD_EN
        chk("win_cx", 72'(win_cx), 72'(exp_cx));
        chk("win_cy", 72'(win_cy), 72'(exp_cy));
`endif
        if (win_valid === 1'b1) obs_win++;
        if (start_flag === 1'b1) begin
            obs_start++;
            first_win = win;
        end
        if (eof_flag === 1'b1) begin
            obs_eof++;
            last_br = win[71:64];
        end
    endtask

    // Expected outputs after the coming clock edge, from raster position rules.
    task automatic model_step(input logic v, input logic s, input logic [7:0] d);
        int r, c;
        exp_valid = 1'b0;
        exp_start = 1'b0;
        exp_eof   = 1'b0;
        if (v) begin
            r = s ? 0 : mr;
            c = s ? 0 : mc;
            img[r][c] = d;
            if (r >= 2 && c >= 2) begin
                exp_valid = 1'b1;
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        exp_win[(i*3+j)*8 +: 8] = img[r-2+i][c-2+j];
                win_known = 1'b1;
                exp_start = (r == 2 && c == 2);
                exp_eof   = (r == H-1 && c == W-1);
                exp_cx    = 3'(c - 1);
                exp_cy    = 3'(r - 1);
            end else begin
                win_known = 1'b0;
            end
            c++;
            if (c == W) begin
                c = 0;
                r++;
                if (r == H) r = 0;
            end
            mr = r;
            mc = c;
        end
    endtask

    task automatic cycle(input logic v, input logic s, input logic [7:0] d);
        @(negedge clk);
        check_outputs();
        din_valid = v;
        sof       = s;
        din       = d;
        model_step(v, s, d);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        check_outputs();
        rst       = 1'b0;
        din_valid = 1'b0;
        sof       = 1'b0;
        exp_valid = 1'b0;
        exp_start = 1'b0;
        exp_eof   = 1'b0;
        exp_win   = '0;
        win_known = 1'b1;
        exp_cx    = '0;
        exp_cy    = '0;
        mr        = 0;
        mc        = 0;
        @(negedge clk);
        check_outputs();
        rst = 1'b1;
    endtask

    task automatic clear_counts();
        obs_win   = 0;
        obs_start = 0;
        obs_eof   = 0;
    endtask

    // mode 0: continuous, 1: idle after every beat, 2: random idles and garbage din
    task automatic feed_frame(input logic first_sof, input int mode, input logic [7:0] tag,
                              input int n_beats);
        int r, c;
        for (int i = 0; i < n_beats; i++) begin
            r = i / W;
            c = i % W;
            cycle(1'b1, first_sof && (i == 0), 8'((r*16 + c)) ^ tag);
            if (mode == 1) cycle(1'b0, 1'b0, 8'($urandom));
            if (mode == 2) begin
                int gaps;
                gaps = $urandom_range(0, 2);
                for (int g = 0; g < gaps; g++) cycle(1'b0, 1'(($urandom_range(0, 1))), 8'($urandom));
            end
        end
    endtask

    localparam logic [71:0] FIRST_WIN = 72'h22_21_20_12_11_10_02_01_00;

    initial begin
        apply_reset();

        // continuous frame with sof
        clear_counts();
        feed_frame(1'b1, 0, 8'h00, W*H);
        cycle(1'b0, 1'b0, 8'h00);
        chk("s1_win_count", 72'(obs_win), 72'd24);
        chk("s1_start_count", 72'(obs_start), 72'd1);
        chk("s1_eof_count", 72'(obs_eof), 72'd1);
        chk("s1_first_win", first_win, FIRST_WIN);
        chk("s1_last_br", 72'(last_br), 72'h57);

        // alternating valid
        clear_counts();
        feed_frame(1'b1, 1, 8'h00, W*H);
        cycle(1'b0, 1'b0, 8'h00);
        chk("s2_win_count", 72'(obs_win), 72'd24);
        chk("s2_first_win", first_win, FIRST_WIN);
        chk("s2_last_br", 72'(last_br), 72'h57);

        // sof mid-frame at row 3, col 4
        clear_counts();
        feed_frame(1'b1, 0, 8'h00, 28);
        feed_frame(1'b1, 0, 8'h80, W*H);
        cycle(1'b0, 1'b0, 8'h00);
        chk("s3_win_count", 72'(obs_win), 72'd32);
        chk("s3_start_count", 72'(obs_start), 72'd2);
        chk("s3_first_win", first_win, FIRST_WIN ^ {9{8'h80}});

        // reset mid-frame, then restart without sof
        feed_frame(1'b1, 0, 8'h00, 20);
        apply_reset();
        clear_counts();
        feed_frame(1'b0, 0, 8'h00, W*H);
        cycle(1'b0, 1'b0, 8'h00);
        chk("s4_win_count", 72'(obs_win), 72'd24);
        chk("s4_first_win", first_win, FIRST_WIN);
        chk("s4_last_br", 72'(last_br), 72'h57);

        // back-to-back frames, sof only on the first
        clear_counts();
        feed_frame(1'b1, 0, 8'h00, W*H);
        feed_frame(1'b0, 0, 8'h40, W*H);
        cycle(1'b0, 1'b0, 8'h00);
        chk("s5_win_count", 72'(obs_win), 72'd48);
        chk("s5_start_count", 72'(obs_start), 72'd2);
        chk("s5_eof_count", 72'(obs_eof), 72'd2);
        chk("s5_first_win", first_win, FIRST_WIN ^ {9{8'h40}});

        // random stalls between beats, and stray sof on idle cycles
        clear_counts();
        feed_frame(1'b1, 2, 8'h0f, W*H);
        feed_frame(1'b0, 2, 8'hf0, W*H);
        cycle(1'b0, 1'b0, 8'h00);
        chk("s6_win_count", 72'(obs_win), 72'd48);

        // fully random data, valid and occasional sof
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 49) == 0), 8'($urandom));
        end
        cycle(1'b0, 1'b0, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
